sobel_stream: RTL and testbench
===============================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 720, pixels per row (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 540, rows per frame (>=3).
REQ-003 SHALL have parameter DWIDTH_IN, default 8, grayscale input pixel width.
REQ-004 SHALL have parameter DWIDTH_OUT, default 8, output pixel width.
REQ-005 SHALL have parameter THRESH, default 64, binarisation threshold (used only with REQ-028).
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 fifo_in_rd_en  output  1  pops one input pixel.
REQ-009 fifo_in_dout  input  DWIDTH_IN  raster-order pixel, first-word-fall-through.
REQ-010 fifo_in_empty  input  1  input FIFO empty.
REQ-011 fifo_out_wr_en  output  1  pushes fifo_out_din.
REQ-012 fifo_out_din  output  DWIDTH_OUT  gradient pixel.
REQ-013 fifo_out_full  input  1  output FIFO full.

Function
REQ-014 SHALL hold two line buffers of IMG_WIDTH entries plus a 3x3 window, so one input pixel is read per accepted transfer (no 3-pixel-wide input).
REQ-015 SHALL implement FSM FILL -> RUN -> FLUSH -> FILL; reset state FILL.
REQ-016 FILL: pops first IMG_WIDTH+1 pixels of a frame, writes nothing, then enters RUN.
REQ-017 RUN: each popped pixel k (k = IMG_WIDTH+1 .. W*H-1) produces exactly one output for centre pixel k-IMG_WIDTH-1; after pixel W*H-1 enters FLUSH.
REQ-018 FLUSH: writes IMG_WIDTH+1 zero pixels, reads nothing, then enters FILL for the next frame.
REQ-019 Each frame SHALL yield exactly IMG_WIDTH*IMG_HEIGHT outputs in raster order.
REQ-020 Border centres (x=0, x=W-1, y=0, y=H-1) SHALL output 0.
REQ-021 Interior: gx = right column minus left column, weights 1,2,1; gy = top row minus bottom row, weights 1,2,1; signed, at least 11 bits, no overflow.
REQ-022 Output = min(255, (|gx|+|gy|)>>1), computed with at least 12-bit unsigned sum.
REQ-023 Output stage SHALL be a single registered slot (out_valid, data); fifo_out_wr_en = out_valid AND NOT fifo_out_full, combinational.
REQ-024 Pipeline advances when NOT out_valid OR NOT fifo_out_full; fifo_in_rd_en = advance AND NOT fifo_in_empty AND state in {FILL, RUN}.
REQ-025 Latency: output for accepted RUN pixel valid on fifo_out_din the cycle after the pop.
REQ-026 fifo_in_empty and fifo_out_full asserted together SHALL stall with no state, counter or buffer change; no pixel dropped or duplicated.
REQ-027 Column/row counters SHALL wrap at IMG_WIDTH-1 / IMG_HEIGHT-1 to 0 at frame end.

Configuration
REQ-028 With SOBEL_THRESHOLD_EN defined, interior output SHALL be 255 if REQ-022 value >= THRESH else 0; undefined, output is the REQ-022 value; borders are 0 in both cases.

Reset
REQ-029 Reset SHALL clear out_valid, data, counters, window and line buffers to 0 and force state FILL; fifo_in_rd_en, fifo_out_wr_en, fifo_out_din are 0 during and the cycle after reset.
REQ-030 Reset mid-frame SHALL discard the partial frame; next popped pixel is treated as pixel 0 of a new frame.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6)
REQ-031 Constant frame of 100 -> 48 outputs, all 0; 9 pops before first write; last 9 writes occur after final pop.
REQ-032 Columns 0-3 = 0, columns 4-7 = 40 -> interior x=3 and x=4 output 80, all others 0.
REQ-033 Columns 0-3 = 0, columns 4-7 = 255 -> interior x=3,4 output 255 (saturated from 510).
REQ-034 fifo_out_full held high 10 cycles mid-RUN -> no writes, at most one further pop, output stream identical to unstalled run.
REQ-035 Reset asserted after 20 pops, then full constant-50 frame -> exactly 48 zero outputs, nothing from aborted frame.
REQ-036 SOBEL_THRESHOLD_EN, THRESH=64: step 0->40 gives 255 at x=3,4; step 0->20 (value 40) gives all 0.

Source files
------------

// File: rtl/sobel_stream_if.sv
// FIFO-side bundle for sobel_stream: FWFT input FIFO read port and output FIFO write port.
// master = the filter, slave = whoever owns the FIFOs.
interface sobel_stream_if #(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 8
);
  logic                  fifo_in_rd_en;
  logic [DWIDTH_IN-1:0]  fifo_in_dout;
  logic                  fifo_in_empty;
  logic                  fifo_out_wr_en;
  logic [DWIDTH_OUT-1:0] fifo_out_din;
  logic                  fifo_out_full;

  modport master (
    output fifo_in_rd_en,  input  fifo_in_dout,  input  fifo_in_empty,
    output fifo_out_wr_en, output fifo_out_din,  input  fifo_out_full
  );
  modport slave (
    input  fifo_in_rd_en,  output fifo_in_dout,  output fifo_in_empty,
    input  fifo_out_wr_en, input  fifo_out_din,  output fifo_out_full
  );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel magnitude filter, one pixel in / one pixel out per transfer.
// Define SOBEL_THRESHOLD_EN to binarise interior outputs against THRESH.
module sobel_stream #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 8,
  parameter int THRESH     = 64
) (
  input  logic           clock,
  input  logic           reset,
  sobel_stream_if.master fifo
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 1);
  localparam int GW = DWIDTH_IN + 3;
  localparam int SW = GW + 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);
  localparam logic [SW-1:0] OUT_MAX    = SW'((1 << DWIDTH_OUT) - 1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [FW-1:0]         flush_q, flush_d;
  logic                  rst_dly_q;
  logic                  out_valid_q, out_valid_d;
  logic [DWIDTH_OUT-1:0] out_data_q, out_data_d;
  logic [DWIDTH_IN-1:0]  lb0_q [IMG_WIDTH];
  logic [DWIDTH_IN-1:0]  lb1_q [IMG_WIDTH];
  // win_q[row][0] = column x-2, win_q[row][1] = column x-1; row 0 is top
  logic [2:0][1:0][DWIDTH_IN-1:0] win_q;

  logic                 advance, pop, interior;
  logic [DWIDTH_IN-1:0] top, mid, bot;
  logic [GW-1:0]        gx, gy, abs_x, abs_y;
  logic [SW-1:0]        mag_sum, mag_half;
  logic [DWIDTH_OUT-1:0] mag;

  function automatic logic [GW-1:0] wsum(input logic [DWIDTH_IN-1:0] a, b, c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  assign advance = !out_valid_q || !fifo.fifo_out_full;
  assign pop     = advance && !fifo.fifo_in_empty && (state_q != FLUSH) && !reset && !rst_dly_q;

  assign fifo.fifo_in_rd_en  = pop;
  assign fifo.fifo_out_wr_en = out_valid_q && !fifo.fifo_out_full;
  assign fifo.fifo_out_din   = out_data_q;

  // Incoming pixel completes the right column; centre sits at column x-1, row y-1
  assign top = lb1_q[col_q];
  assign mid = lb0_q[col_q];
  assign bot = fifo.fifo_in_dout;

  assign gx = wsum(top, mid, bot) - wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
  assign gy = wsum(win_q[0][0], win_q[0][1], top) - wsum(win_q[2][0], win_q[2][1], bot);
  assign abs_x    = gx[GW-1] ? (~gx + GW'(1)) : gx;
  assign abs_y    = gy[GW-1] ? (~gy + GW'(1)) : gy;
  assign mag_sum  = SW'(abs_x) + SW'(abs_y);
  assign mag_half = mag_sum >> 1;

`ifdef SOBEL_THRESHOLD_EN
  assign mag = (mag_half >= SW'(THRESH)) ? '1 : '0;
`else
  assign mag = (mag_half > OUT_MAX) ? '1 : DWIDTH_OUT'(mag_half);
`endif

  // Centre column 1..W-2 and row >= 1 reduce to these tests on the incoming pixel
  assign interior = (col_q >= CW'(2)) && (row_q >= RW'(2));

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    flush_d     = flush_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (advance) out_valid_d = 1'b0;
    if (pop) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
      if (col_q == COL_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end
    case (state_q)
      FILL: if (pop && col_q == '0 && row_q == RW'(1)) state_d = RUN;
      RUN: if (pop) begin
        out_valid_d = 1'b1;
        out_data_d  = interior ? mag : '0;
        if (col_q == COL_LAST && row_q == ROW_LAST) state_d = FLUSH;
      end
      FLUSH: if (advance) begin
        out_valid_d = 1'b1;
        out_data_d  = '0;
        if (flush_q == FLUSH_LAST) begin
          flush_d = '0;
          state_d = FILL;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      flush_q     <= '0;
      rst_dly_q   <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      win_q       <= '0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      rst_dly_q   <= 1'b0;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (pop) begin
        lb1_q[col_q] <= mid;
        lb0_q[col_q] <= bot;
        win_q[0] <= {top, win_q[0][1]};
        win_q[1] <= {mid, win_q[1][1]};
        win_q[2] <= {bot, win_q[2][1]};
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on an 8x6 image: driver feeds a modelled FWFT FIFO,
// monitor checks every output write against a frame-level Sobel reference.
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sobel_stream_if #(.DWIDTH_IN(8), .DWIDTH_OUT(8)) ifc ();
  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clock(clock), .reset(reset), .fifo(ifc.master));

  int in_q[$];
  int exp_q[$];
  int pw_q[$];
  int img[H][W];
  int vectors = 0, miscompares = 0;
  bit rand_empty = 0, rand_full = 0, force_full = 0, abort_mode = 0;
  int mon_pops = 0, mon_writes = 0, last_pop_writes = 0;

  task automatic check(input string nm, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int absv(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: straight 2D Sobel on the stored frame
  function automatic int ref_pix(input int y, input int x);
    int gx, gy, m;
    if (y == 0 || y == H-1 || x == 0 || x == W-1) return 0;
    gx = (img[y-1][x+1] + 2*img[y][x+1] + img[y+1][x+1]) - (img[y-1][x-1] + 2*img[y][x-1] + img[y+1][x-1]);
    gy = (img[y-1][x-1] + 2*img[y-1][x] + img[y-1][x+1]) - (img[y+1][x-1] + 2*img[y+1][x] + img[y+1][x+1]);
    m = (absv(gx) + absv(gy)) / 2;
    if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
    m = (m >= 64) ? 255 : 0;
`endif
    return m;
  endfunction

  // kind 0: constant a; kind 1: columns 0-3 = a, 4-7 = b; kind 2: random
  task automatic send_frame(input int kind, input int a, input int b, input bit with_exp);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img[y][x] = (kind == 0) ? a : (kind == 1) ? ((x < 4) ? a : b) : int'($urandom_range(255));
        in_q.push_back(img[y][x]);
      end
    if (with_exp)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) exp_q.push_back(ref_pix(y, x));
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && t < 3000) begin
      @(posedge clock);
      t++;
    end
    #2;
    check("drain_in_time", (t < 3000) ? 1 : 0, 1);
    repeat (3) @(posedge clock);
    #2;
  endtask

  task automatic wait_pops(input int base, input int n);
    int t = 0;
    while (mon_pops - base < n && t < 2000) begin
      @(posedge clock);
      t++;
    end
    #2;
    check("pops_reached", (t < 2000) ? 1 : 0, 1);
  endtask

  // Driver: FWFT input FIFO and output-FIFO full, updated on the falling edge
  initial begin
    ifc.fifo_in_empty = 1'b1;
    ifc.fifo_in_dout  = '0;
    ifc.fifo_out_full = 1'b0;
    forever begin
      @(negedge clock);
      ifc.fifo_in_empty = (in_q.size() == 0) || (rand_empty && $urandom_range(3) == 0);
      ifc.fifo_in_dout  = (in_q.size() != 0) ? 8'(in_q[0]) : 8'd0;
      ifc.fifo_out_full = force_full || (rand_full && $urandom_range(3) == 0);
      #1;
      if (ifc.fifo_in_rd_en) begin
        if (in_q.size() == 0) check("pop_from_empty", 1, 0);
        else void'(in_q.pop_front());
      end
    end
  end

  // Monitor: pops expected outputs on every write
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (ifc.fifo_out_wr_en) begin
        pw_q.push_back(mon_pops);
        mon_writes++;
        if (!abort_mode) begin
          if (exp_q.size() == 0) check("unexpected_write", int'(ifc.fifo_out_din), -1);
          else check("pixel", int'(ifc.fifo_out_din), exp_q.pop_front());
        end
      end
      if (ifc.fifo_in_rd_en) begin
        mon_pops++;
        last_pop_writes = mon_writes;
      end
    end
  end

  initial begin
    int bp, bw, bi;
    repeat (2) begin
      @(posedge clock);
      #2;
      check("reset_rd_en", int'(ifc.fifo_in_rd_en), 0);
      check("reset_wr_en", int'(ifc.fifo_out_wr_en), 0);
      check("reset_din", int'(ifc.fifo_out_din), 0);
    end
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;

    // Constant frame: all zero, fill/flush framing
    bp = mon_pops; bw = mon_writes; bi = pw_q.size();
    send_frame(0, 100, 100, 1);
    wait_drain();
    check("const_writes", mon_writes - bw, W*H);
    check_rng("pops_before_first_write", pw_q[bi] - bp, W+1, W+2);
    check_rng("writes_after_last_pop", mon_writes - last_pop_writes, W+1, W+2);

    send_frame(1, 0, 40, 1);  wait_drain();
    send_frame(1, 0, 255, 1); wait_drain();
    send_frame(1, 0, 20, 1);  wait_drain();

    // Random frames with random empty/full back-pressure
    rand_empty = 1; rand_full = 1;
    for (int f = 0; f < 4; f++) begin
      send_frame(2, 0, 0, 1);
      if (f == 1) send_frame(2, 0, 0, 1);
      wait_drain();
    end
    rand_empty = 0; rand_full = 0;

    // Output held full for 10 cycles mid-frame
    bp = mon_pops;
    send_frame(2, 0, 0, 1);
    wait_pops(bp, 20);
    force_full = 1;
    @(negedge clock);
    #3;
    bp = mon_pops; bw = mon_writes;
    repeat (10) @(negedge clock);
    #3;
    check_rng("stall_pops", mon_pops - bp, 0, 1);
    check("stall_writes", mon_writes - bw, 0);
    @(posedge clock);
    #2;
    force_full = 0;
    wait_drain();

    // Abort a frame after 20 pops; next frame must be clean
    abort_mode = 1;
    bp = mon_pops;
    send_frame(0, 77, 77, 0);
    wait_pops(bp, 20);
    reset = 1'b1;
    @(posedge clock);
    #2;
    abort_mode = 0;
    check("abort_reset_rd_en", int'(ifc.fifo_in_rd_en), 0);
    check("abort_reset_wr_en", int'(ifc.fifo_out_wr_en), 0);
    check("abort_reset_din", int'(ifc.fifo_out_din), 0);
    @(posedge clock);
    #2;
    in_q.delete();
    bw = mon_writes;
    send_frame(0, 50, 50, 1);
    reset = 1'b0;
    #1;
    check("post_reset_rd_en", int'(ifc.fifo_in_rd_en), 0);
    check("post_reset_wr_en", int'(ifc.fifo_out_wr_en), 0);
    wait_drain();
    repeat (20) @(posedge clock);
    #2;
    check("abort_then_frame_writes", mon_writes - bw, W*H);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
